data_memory: RTL



---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/dm_latency_counter.sv | 32 +++
 rtl/data_memory.sv | 139 +++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory responder: FSM encodings, access
// opcode and latency-counter sizing.
package data_memory_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  typedef enum logic {
    DM_OP_READ  = 1'b0,
    DM_OP_WRITE = 1'b1
  } dm_op_e;

  localparam int DM_DEFAULT_LATENCY = 5;

  // Wide enough for the largest legal latency (15).
  localparam int DM_CNT_W = 4;

endpackage

// File: rtl/dm_latency_counter.sv
// Loadable down-counter that times the BUSY phase of a memory access.
// Saturates at zero; load has priority over decrement.
module dm_latency_counter
  import data_memory_pkg::*;
#(
  parameter int WIDTH = DM_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/data_memory.sv
// Byte-wide data memory answering the CPU READMEM/WRITEMEM handshake with a
// fixed latency, stalling the CPU through BUSYWAIT while an access is open.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = DM_DEFAULT_LATENCY  // legal range 1..15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READMEM,
  input  logic              WRITEMEM,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT,
  output logic              PROTOCOL_ERR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DM_CNT_W-1:0] LOAD_VAL = DM_CNT_W'(LATENCY - 1);

  dm_state_e         r_state;
  dm_state_e         w_next_state;
  dm_op_e            r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_readdata;
  logic              r_protocol_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_conflict;
  logic w_complete;
  logic w_cnt_dec;
  logic w_cnt_zero;

  dm_latency_counter #(
    .WIDTH (DM_CNT_W)
  ) u_latency_counter (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= DM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    BUSYWAIT     = 1'b0;
    w_accept     = 1'b0;
    w_conflict   = 1'b0;
    w_complete   = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      DM_IDLE: begin
        // Combinational stall so the CPU freezes before the first edge.
        BUSYWAIT   = READMEM ^ WRITEMEM;
        w_accept   = READMEM ^ WRITEMEM;
        w_conflict = READMEM & WRITEMEM;
        if (w_accept) begin
          w_next_state = DM_BUSY;
        end
      end
      DM_BUSY: begin
        BUSYWAIT = 1'b1;
        if (w_cnt_zero) begin
          w_complete   = 1'b1;
          w_next_state = DM_DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      DM_DONE: begin
        // Requests are ignored here so a still-held request is not replayed.
        w_next_state = DM_IDLE;
      end
      default: begin
        w_next_state = DM_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op    <= DM_OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_op    <= WRITEMEM ? DM_OP_WRITE : DM_OP_READ;
      r_addr  <= ADDRESS;
      r_wdata <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_protocol_err <= 1'b0;
    end else if (w_conflict) begin
      r_protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_readdata <= '0;
    end else if (w_complete && (r_op == DM_OP_READ)) begin
      r_readdata <= r_mem[r_addr];
    end
  end

  // NOTE: the storage array is cleared by reset, which forces it into flops
  // rather than a RAM macro; an abandoned access never reaches the write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_complete && (r_op == DM_OP_WRITE)) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign READDATA     = r_readdata;
  assign PROTOCOL_ERR = r_protocol_err;

endmodule
